// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing (pixel divider, h/v counters, sync/video decode) with frame-committed shadow timing regs; ports: clk/rst, start/stop, cfg_we/cfg_addr/cfg_wdata -> cfg_err/cfg_pending, busy, pix_en, h_count/v_count, hsync/vsync/video_on, line_start/frame_start
module vga_timing_ctrl #(
  parameter int CLK_DIV = 4,
  parameter logic [15:0] H_TOTAL = 16'd800,
  parameter logic [15:0] H_ACTIVE = 16'd640,
  parameter logic [15:0] H_SYNC_START = 16'd656,
  parameter logic [15:0] H_SYNC_END = 16'd752,
  parameter logic [15:0] V_TOTAL = 16'd525,
  parameter logic [15:0] V_ACTIVE = 16'd480,
  parameter logic [15:0] V_SYNC_START = 16'd490,
  parameter logic [15:0] V_SYNC_END = 16'd492,
  parameter bit HS_POL = 1'b0,
  parameter bit VS_POL = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        stop,
  input  logic        cfg_we,
  input  logic [2:0]  cfg_addr,
  input  logic [15:0] cfg_wdata,
  output logic        cfg_err,
  output logic        cfg_pending,
  output logic        busy,
  output logic        pix_en,
  output logic [15:0] h_count,
  output logic [15:0] v_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic        line_start,
  output logic        frame_start
);
  typedef enum logic [1:0] {IDLE, RUN, STOPPING} state_t;
  localparam logic [15:0] DIV_MAX = 16'(CLK_DIV - 1);
  localparam logic [7:0][15:0] DEF = {V_SYNC_END, V_SYNC_START, V_ACTIVE, V_TOTAL,
                                      H_SYNC_END, H_SYNC_START, H_ACTIVE, H_TOTAL};
  state_t state, state_nx;
  logic [7:0][15:0] sh, act, sh_nx, act_nx;
  logic [15:0] div, div_nx, h_nx, v_nx;
  logic go, h_wrap, fb, rej, run_nx, ls_nx;
  always_comb begin
    go = state == IDLE && start;
    h_wrap = pix_en && h_count == act[0] - 16'd1;
    fb = h_wrap && v_count == act[4] - 16'd1;
    state_nx = state == IDLE ? (start ? RUN : IDLE)
             : state == RUN ? (stop && !start ? STOPPING : RUN)
             : start ? RUN : fb ? IDLE : STOPPING;
    run_nx = state_nx != IDLE;
    act_nx = go || fb ? sh : act;
    rej = (cfg_addr == 3'd0 || cfg_addr == 3'd4) && cfg_wdata < 16'd2;
    sh_nx = sh;
    if (cfg_we && !rej) sh_nx[cfg_addr] = cfg_wdata;
    div_nx = !run_nx || go || div == DIV_MAX ? '0 : div + 16'd1;
    h_nx = !run_nx || go || h_wrap ? '0 : h_count + 16'(pix_en);
    v_nx = !run_nx || go || fb ? '0 : h_wrap ? v_count + 16'd1 : v_count;
    ls_nx = run_nx && h_nx == '0 && (go || pix_en);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sh <= DEF;
      act <= DEF;
      div <= '0;
      h_count <= '0;
      v_count <= '0;
      pix_en <= 1'b0;
      busy <= 1'b0;
      hsync <= !HS_POL;
      vsync <= !VS_POL;
      video_on <= 1'b0;
      line_start <= 1'b0;
      frame_start <= 1'b0;
      cfg_err <= 1'b0;
      cfg_pending <= 1'b0;
    end else begin
      state <= state_nx;
      sh <= sh_nx;
      act <= act_nx;
      div <= div_nx;
      h_count <= h_nx;
      v_count <= v_nx;
      pix_en <= run_nx && div_nx == DIV_MAX;
      busy <= run_nx;
      hsync <= run_nx && h_nx >= act_nx[2] && h_nx < act_nx[3] ? HS_POL : !HS_POL;
      vsync <= run_nx && v_nx >= act_nx[6] && v_nx < act_nx[7] ? VS_POL : !VS_POL;
      video_on <= run_nx && h_nx < act_nx[1] && v_nx < act_nx[5];
      line_start <= ls_nx;
      frame_start <= ls_nx && v_nx == '0;
      cfg_err <= cfg_we && rej;
      cfg_pending <= sh_nx != act_nx;
    end
  end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench driving CLK_DIV=4 and CLK_DIV=1 instances in lockstep against a frame-level timing model
module tb_vga_timing_ctrl;
  typedef logic [7:0][15:0] cfg_t;
  typedef struct {
    int d;
    logic [15:0] h, v;
    logic hs, vs, vo, pe, ls, fs, bz, er, pd;
  } exp_t;
  localparam cfg_t DEF = {16'd492, 16'd490, 16'd480, 16'd525, 16'd752, 16'd656, 16'd640, 16'd800};
  localparam cfg_t CA = {16'd4, 16'd3, 16'd2, 16'd4, 16'd8, 16'd7, 16'd6, 16'd10};
  localparam cfg_t CB = {16'd3, 16'd3, 16'd3, 16'd5, 16'd11, 16'd9, 16'd8, 16'd12};
  logic clk = 1'b0;
  logic rst, start, stop, cfg_we;
  logic [2:0] cfg_addr;
  logic [15:0] cfg_wdata;
  logic [1:0] err, pend, bz, pe, hs, vs, vo, ls, fs;
  logic [1:0][15:0] hc, vc;
  int checks = 0;
  int errors = 0;
  exp_t q[$];
  int rel[2];
  bit run_m[2], stp[2];
  cfg_t cur[2], shm[2];
  int cdv[2] = '{4, 1};
  always #5 clk = ~clk;
  vga_timing_ctrl dut0 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(err[0]), .cfg_pending(pend[0]), .busy(bz[0]), .pix_en(pe[0]),
    .h_count(hc[0]), .v_count(vc[0]), .hsync(hs[0]), .vsync(vs[0]), .video_on(vo[0]),
    .line_start(ls[0]), .frame_start(fs[0])
  );
  vga_timing_ctrl #(.CLK_DIV(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .cfg_we(cfg_we), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(err[1]), .cfg_pending(pend[1]), .busy(bz[1]), .pix_en(pe[1]),
    .h_count(hc[1]), .v_count(vc[1]), .hsync(hs[1]), .vsync(vs[1]), .video_on(vo[1]),
    .line_start(ls[1]), .frame_start(fs[1])
  );
  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic model(int d);
    exp_t e;
    int c[8];
    int n, h, v, cd;
    bit rj, r;
    rj = (cfg_addr == 3'd0 || cfg_addr == 3'd4) && cfg_wdata < 16'd2;
    cd = cdv[d];
    if (rst) begin
      run_m[d] = 0;
      stp[d] = 0;
      cur[d] = DEF;
      shm[d] = DEF;
      rel[d] = 0;
    end else begin
      if (!run_m[d]) begin
        if (start) begin
          run_m[d] = 1;
          stp[d] = 0;
          cur[d] = shm[d];
          rel[d] = 1;
        end
      end else begin
        if (rel[d] == int'(cur[d][0]) * int'(cur[d][4]) * cd) begin
          cur[d] = shm[d];
          rel[d] = 1;
          if (stp[d] && !start) run_m[d] = 0;
        end else rel[d]++;
        if (start) stp[d] = 0;
        else if (stop) stp[d] = 1;
      end
      if (cfg_we && !rj) shm[d][cfg_addr] = cfg_wdata;
    end
    for (int i = 0; i < 8; i++) c[i] = int'(cur[d][i]);
    r = run_m[d];
    n = r ? (rel[d] - 1) / cd : 0;
    h = n % c[0];
    v = (n / c[0]) % c[4];
    e.d = d;
    e.h = 16'(h);
    e.v = 16'(v);
    e.pe = r && (rel[d] - 1) % cd == cd - 1;
    e.ls = r && (rel[d] - 1) % cd == 0 && h == 0;
    e.fs = e.ls && v == 0;
    e.hs = !(r && h >= c[2] && h < c[3]);
    e.vs = !(r && v >= c[6] && v < c[7]);
    e.vo = r && h < c[1] && v < c[5];
    e.bz = r;
    e.er = !rst && cfg_we && rj;
    e.pd = shm[d] != cur[d];
    q.push_back(e);
  endtask
  task automatic step();
    exp_t e;
    string t;
    model(0);
    model(1);
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e = q.pop_front();
      t = e.d == 1 ? "d1_" : "d0_";
      chk({t, "h_count"}, 32'(hc[e.d]), 32'(e.h));
      chk({t, "v_count"}, 32'(vc[e.d]), 32'(e.v));
      chk({t, "hsync"}, 32'(hs[e.d]), 32'(e.hs));
      chk({t, "vsync"}, 32'(vs[e.d]), 32'(e.vs));
      chk({t, "video_on"}, 32'(vo[e.d]), 32'(e.vo));
      chk({t, "pix_en"}, 32'(pe[e.d]), 32'(e.pe));
      chk({t, "line_start"}, 32'(ls[e.d]), 32'(e.ls));
      chk({t, "frame_start"}, 32'(fs[e.d]), 32'(e.fs));
      chk({t, "busy"}, 32'(bz[e.d]), 32'(e.bz));
      chk({t, "cfg_err"}, 32'(err[e.d]), 32'(e.er));
      chk({t, "cfg_pending"}, 32'(pend[e.d]), 32'(e.pd));
    end
    start = 1'b0;
    stop = 1'b0;
    cfg_we = 1'b0;
  endtask
  task automatic wr(cfg_t c);
    for (int i = 0; i < 8; i++) begin
      cfg_we = 1'b1;
      cfg_addr = 3'(i);
      cfg_wdata = c[i];
      step();
    end
  endtask
  task automatic bad(logic [2:0] a, logic [15:0] v);
    cfg_we = 1'b1;
    cfg_addr = a;
    cfg_wdata = v;
    step();
  endtask
  initial begin
    rst = 1'b1;
    start = 1'b0;
    stop = 1'b0;
    cfg_we = 1'b0;
    cfg_addr = '0;
    cfg_wdata = '0;
    repeat (2) step();
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    repeat (3300) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    wr(CA);
    bad(3'd0, 16'd1);
    bad(3'd4, 16'd0);
    step();
    start = 1'b1;
    step();
    repeat (50) step();
    wr(CB);
    repeat (400) step();
    wr(CA);
    stop = 1'b1;
    step();
    repeat (600) step();
    start = 1'b1;
    stop = 1'b1;
    step();
    repeat (20) step();
    stop = 1'b1;
    step();
    repeat (30) step();
    start = 1'b1;
    step();
    repeat (400) step();
    bad(3'd0, 16'd1);
    repeat (5) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    start = 1'b1;
    step();
    repeat (900) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
